// File: rtl/iob_bridge_if.sv
// FSB request side and 68000-style I/O bus of the I/O-bus bridge.
interface iob_bridge_if;
  logic ASActive;
  logic ASInactive;
  logic IOCS;
  logic IACS;
  logic nWE;
  logic IOnDTACK;
  logic IOnVPA;
  logic IOASOut;
  logic IOLatch;
  logic IOE;
  logic IORDY;
  logic IOBERR;

  modport master (
    output ASActive, ASInactive, IOCS, IACS, nWE,
    output IOnDTACK, IOnVPA,
    input  IOASOut, IOLatch, IOE, IORDY, IOBERR
  );

  modport slave (
    input  ASActive, ASInactive, IOCS, IACS, nWE,
    input  IOnDTACK, IOnVPA,
    output IOASOut, IOLatch, IOE, IORDY, IOBERR
  );
endinterface

// File: rtl/iob_bridge.sv
// I/O-bus cycle engine: runs DTACK or VPA/E-synchronous cycles
// for decoded FSB requests, with posted writes and timeout.
module iob_bridge #(
  parameter int EDIV    = 10,
  parameter int EHIGH   = 4,
  parameter int TIMEOUT = 63,
  parameter int RECOV   = 2,
  parameter int POSTWR  = 1
) (
  input logic         CLK,
  input logic         RES,
  iob_bridge_if.slave bus
);
  localparam int EW = (EDIV > 1) ? $clog2(EDIV) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACT,
    S_VPAW,
    S_LATCH,
    S_REC
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [EW-1:0] r_ecnt;
  logic [EW-1:0] w_ecnt_nxt;
  logic [TW-1:0] r_cnt;
  logic          r_e;
  logic          r_taken;
  logic          r_wr;
  logic          r_iack;
  logic          r_abort;
  logic          r_rdy;
  logic          r_berr;
  logic          w_req;
  logic          w_cap;
  logic          w_to;
  logic          w_post_in;
  logic          w_posted;
  logic          w_busy;

  assign w_ecnt_nxt = (r_ecnt == EW'(EDIV - 1)) ?
                      '0 : r_ecnt + 1'b1;
  assign w_req = bus.ASActive & (bus.IOCS | bus.IACS)
               & ~r_taken;
  assign w_post_in = (POSTWR != 0) & ~bus.nWE & ~bus.IACS;
  assign w_posted  = (POSTWR != 0) & r_wr & ~r_iack;
  assign w_busy    = (r_state == S_ACT)
                   | (r_state == S_VPAW);

  always_comb begin
    w_next = r_state;
    w_cap  = 1'b0;
    w_to   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_next = S_ACT;
          w_cap  = 1'b1;
        end
      end
      S_ACT: begin
        if (!bus.IOnDTACK) begin
          w_next = S_LATCH;
        end else if (!bus.IOnVPA) begin
          w_next = S_VPAW;
        end else if (r_cnt == TW'(TIMEOUT)) begin
          w_next = S_REC;
          w_to   = 1'b1;
        end
      end
      // Latch lands on the last E-high cycle of the period.
      S_VPAW: begin
        if (w_ecnt_nxt == EW'(EDIV - 1))
          w_next = S_LATCH;
      end
      S_LATCH: w_next = S_REC;
      S_REC: begin
        if (r_cnt == TW'(RECOV - 1))
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      r_state <= S_IDLE;
      r_ecnt  <= '0;
      r_e     <= 1'b0;
      r_cnt   <= '0;
      r_taken <= 1'b0;
      r_wr    <= 1'b0;
      r_iack  <= 1'b0;
      r_abort <= 1'b0;
      r_rdy   <= 1'b0;
      r_berr  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ecnt  <= w_ecnt_nxt;
      r_e     <= (w_ecnt_nxt >= EW'(EDIV - EHIGH));
      // One counter serves ACT timeout and REC idle time.
      if (w_next != r_state)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      if (bus.ASInactive)
        r_taken <= 1'b0;
      else if (w_cap)
        r_taken <= 1'b1;
      if (w_cap) begin
        r_wr   <= ~bus.nWE;
        r_iack <= bus.IACS;
      end
      if (w_cap)
        r_abort <= 1'b0;
      else if (bus.ASInactive && w_busy)
        r_abort <= 1'b1;
      if (bus.ASInactive)
        r_rdy <= 1'b0;
      else if (w_cap && w_post_in)
        r_rdy <= 1'b1;
      else if (r_state == S_LATCH && !w_posted && !r_abort)
        r_rdy <= 1'b1;
      if (bus.ASInactive)
        r_berr <= 1'b0;
      else if (w_to && !w_posted && !r_abort)
        r_berr <= 1'b1;
    end
  end

  assign bus.IOASOut = (r_state == S_ACT)
                     | (r_state == S_VPAW)
                     | (r_state == S_LATCH);
  assign bus.IOLatch = (r_state == S_LATCH);
  assign bus.IOE     = r_e;
  assign bus.IORDY   = r_rdy;
  assign bus.IOBERR  = r_berr;
endmodule

// File: tb/tb_iob_bridge.sv
// Bench for iob_bridge: vector table, corner sequences and
// random transactions against a cycle-timing model.
module tb_iob_bridge;
  localparam int RECOV = 2;
  localparam int R_DT   = 0;
  localparam int R_VPA  = 1;
  localparam int R_BOTH = 2;
  localparam int R_NONE = 3;

  typedef struct {
    bit iack;
    bit wr;
    int resp;
    int lat;
    int endat;
    int exp_lat;
    int exp_rdy;
    int exp_berr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   ecnt = 0;
  vec_t tbl [12];

  always #5 clk = ~clk;

  iob_bridge_if bus();

  iob_bridge #(
    .EDIV(10), .EHIGH(4), .TIMEOUT(63),
    .RECOV(RECOV), .POSTWR(1)
  ) dut (
    .CLK(clk),
    .RES(rst),
    .bus(bus)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ecnt = rst ? 0 : (ecnt + 1) % 10;
  endtask

  task automatic chk_e();
    chk($sformatf("ioe ecnt%0d", ecnt), bus.IOE, ecnt >= 6);
  endtask

  task automatic idle_in();
    bus.ASActive   = 1'b0;
    bus.ASInactive = 1'b0;
    bus.IOCS       = 1'b0;
    bus.IACS       = 1'b0;
    bus.nWE        = 1'b1;
    bus.IOnDTACK   = 1'b1;
    bus.IOnVPA     = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    tick();
    rst = 1'b0;
  endtask

  // Cycle 0 is the current cycle; the request is sampled at its end.
  task automatic xact(input bit iack, input bit wr,
                      input int resp, input int lat,
                      input int endat, output int o_lat,
                      output int o_rdy, output int o_berr);
    int e0, latch, last, setc, berrc, jend;
    bit posted, act;
    logic [3:0] ev, gv;
    e0 = ecnt;
    posted = wr && !iack;
    latch = 0;
    last = 64;
    if (resp == R_VPA) begin
      latch = lat + 2;
      while ((e0 + latch) % 10 != 9) latch++;
      last = latch;
    end else if (resp != R_NONE) begin
      latch = lat + 1;
      last = latch;
    end
    setc = posted ? 1 : ((latch != 0) ? latch + 1 : 0);
    berrc = (resp == R_NONE && !posted) ? 65 : 0;
    jend = ((endat > last + RECOV) ? endat : last + RECOV) + 1;
    o_lat = 0;
    o_rdy = 0;
    o_berr = 0;
    bus.ASActive = 1'b1;
    bus.ASInactive = 1'b0;
    bus.IOCS = !iack;
    bus.IACS = iack;
    bus.nWE = !wr;
    for (int j = 1; j <= jend; j++) begin
      tick();
      ev = {j <= last, j == latch,
            setc != 0 && setc <= endat && j >= setc && j <= endat,
            berrc != 0 && berrc <= endat && j >= berrc && j <= endat};
      gv = {bus.IOASOut, bus.IOLatch, bus.IORDY, bus.IOBERR};
      chk($sformatf("cyc%0d as/lt/rdy/berr", j), gv, ev);
      chk_e();
      if (bus.IOLatch === 1'b1 && o_lat == 0) o_lat = j;
      if (bus.IORDY === 1'b1 && o_rdy == 0) o_rdy = j;
      if (bus.IOBERR === 1'b1 && o_berr == 0) o_berr = j;
      bus.ASActive = (j < endat);
      bus.ASInactive = (j == endat);
      if (j >= endat) begin
        bus.IOCS = 1'b0;
        bus.IACS = 1'b0;
      end
      act = (lat != 0) && (j >= lat) && (j <= last);
      bus.IOnDTACK = !(act && (resp == R_DT || resp == R_BOTH));
      bus.IOnVPA = !(act && (resp == R_VPA || resp == R_BOTH));
    end
    bus.ASInactive = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ol, orr, ob, n, gap, r, resp, lat, endat;
    bit iack, wr;
    tbl[0]  = '{0, 0, R_DT,   3, 10, 4, 5, 0};
    tbl[1]  = '{1, 0, R_VPA,  2, 12, 9, 10, 0};
    tbl[2]  = '{0, 0, R_VPA,  7, 12, 9, 10, 0};
    tbl[3]  = '{0, 1, R_DT,   2, 2,  3, 1, 0};
    tbl[4]  = '{1, 1, R_DT,   1, 5,  2, 3, 0};
    tbl[5]  = '{0, 0, R_BOTH, 2, 6,  3, 4, 0};
    tbl[6]  = '{0, 0, R_NONE, 0, 66, 0, 0, 65};
    tbl[7]  = '{0, 1, R_NONE, 0, 3,  0, 1, 0};
    tbl[8]  = '{0, 0, R_DT,   4, 3,  5, 0, 0};
    tbl[9]  = '{1, 0, R_VPA,  1, 4,  9, 0, 0};
    tbl[10] = '{0, 0, R_DT,   2, 3,  3, 0, 0};
    tbl[11] = '{0, 0, R_NONE, 0, 64, 0, 0, 0};

    idle_in();
    for (int i = 0; i < 12; i++) begin
      do_reset();
      xact(tbl[i].iack, tbl[i].wr, tbl[i].resp, tbl[i].lat,
           tbl[i].endat, ol, orr, ob);
      chk($sformatf("row%0d latch", i), ol, tbl[i].exp_lat);
      chk($sformatf("row%0d rdy", i), orr, tbl[i].exp_rdy);
      chk($sformatf("row%0d berr", i), ob, tbl[i].exp_berr);
    end

    // Reset in the middle of a posted write.
    do_reset();
    bus.ASActive = 1'b1;
    bus.IOCS = 1'b1;
    bus.nWE = 1'b0;
    tick();
    tick();
    chk("pre-rst as/rdy", {bus.IOASOut, bus.IORDY}, 2'b11);
    rst = 1'b1;
    idle_in();
    tick();
    rst = 1'b0;
    chk("rst outs", {bus.IOASOut, bus.IOLatch, bus.IORDY,
                     bus.IOBERR, bus.IOE}, 5'b0);
    n = 0;
    while (bus.IOE !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("ioe first rise", n, 6);
    xact(0, 0, R_DT, 1, 4, ol, orr, ob);
    chk("post-rst latch", ol, 2);

    // Second request waiting in REC is captured on first IDLE.
    do_reset();
    bus.ASActive = 1'b1;
    bus.IOCS = 1'b1;
    bus.nWE = 1'b0;
    tick();
    chk("b2b c1 as/rdy", {bus.IOASOut, bus.IORDY}, 2'b11);
    bus.ASActive = 1'b0;
    bus.ASInactive = 1'b1;
    bus.IOnDTACK = 1'b0;
    tick();
    chk("b2b c2 lt/rdy", {bus.IOLatch, bus.IORDY}, 2'b10);
    bus.ASInactive = 1'b0;
    bus.IOnDTACK = 1'b1;
    tick();
    chk("b2b c3 as", bus.IOASOut, 1'b0);
    bus.ASActive = 1'b1;
    bus.IOCS = 1'b1;
    bus.nWE = 1'b1;
    for (int k = 4; k <= 6; k++) begin
      tick();
      chk($sformatf("b2b c%0d as", k), bus.IOASOut, k == 6);
    end

    do_reset();
    for (int t = 0; t < 40; t++) begin
      gap = $urandom_range(0, 7);
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("gap as", bus.IOASOut, 1'b0);
        chk_e();
      end
      iack = 1'($urandom % 2);
      wr = 1'($urandom % 2);
      r = $urandom_range(0, 15);
      resp = (r == 0) ? R_NONE : r % 3;
      lat = (resp == R_NONE) ? 0 : 1 + $urandom % 5;
      if (wr && !iack)
        endat = 1 + $urandom % 4;
      else if (resp == R_NONE)
        endat = 65 + $urandom % 3;
      else if ($urandom % 4 == 0)
        endat = 1 + $urandom % lat;
      else
        endat = 17 + $urandom % 4;
      xact(iack, wr, resp, lat, endat, ol, orr, ob);
      chk($sformatf("rnd%0d latch seen", t), ol != 0,
          resp != R_NONE);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iob_bridge.md
Name: iob_bridge

Overview:
- I/O-bus cycle engine directly downstream of the chip-select decoder.
- Accepts FSB cycles whose decode has IOCS or IACS high, and runs the matching cycle on the 68000-style I/O bus.
- Supports both bus-termination modes: DTACK-terminated cycles, and VPA/E-clock-synchronous cycles (VIA, IACK).
- Signals completion back to the FSB, posts plain writes early, and flags bus timeouts.

Parameters:
EDIV, 10, E-clock period in CLK cycles
EHIGH, 4, CLK cycles per period that E is high
TIMEOUT, 63, max CLK cycles in ACT before abort
RECOV, 2, I/O-bus idle cycles required after every cycle
POSTWR, 1, 1 = non-IACK writes acknowledged to FSB before I/O completion

Ports:
CLK  in  1  system clock
RES  in  1  synchronous active-high reset
ASActive  in  1  FSB address strobe active (level, FSB domain)
ASInactive  in  1  FSB cycle ending (level)
IOCS  in  1  decoded I/O-bus select
IACS  in  1  decoded interrupt-acknowledge select
nWE  in  1  FSB write (low = write)
IOnDTACK  in  1  I/O-bus DTACK, active low, pre-synchronised
IOnVPA  in  1  I/O-bus VPA, active low, pre-synchronised
IOASOut  out  1  I/O-bus strobe enable (drives AS/DS buffers)
IOLatch  out  1  one-cycle read-data latch strobe
IOE  out  1  6800 E clock
IORDY  out  1  FSB may terminate (drives DTACK toward CPU)
IOBERR  out  1  FSB bus error (timeout)

Behaviour:
- Reset: RES at posedge forces the following on the next edge, aborting any cycle in progress:
  - state IDLE, E counter 0, timeout counter 0, Taken 0;
  - all outputs 0.
- E clock:
  - Counter ECnt runs free 0..EDIV-1 and wraps to 0.
  - IOE is registered; it is 1 when ECnt >= EDIV-EHIGH, else 0.
- Request: Req = ASActive & (IOCS | IACS) & ~Taken.
- Taken flag: set on capture, cleared when ASInactive=1. A clear on ASInactive beats a set in the same cycle.
- States: IDLE, ACT, VPAW, LATCH, REC.
- IDLE:
  - On Req, latch Wr=~nWE and Iack=IACS, set Taken, go to ACT.
  - IOASOut=1 from the ACT entry edge, i.e. 1 cycle of latency after capture.
- Posted write: when POSTWR=1, Wr=1 and Iack=0, IORDY rises on the same edge that enters ACT.
- ACT:
  - Timeout counter increments every cycle.
  - IOnDTACK=0 -> LATCH. DTACK has priority if IOnVPA is also 0.
  - Else IOnVPA=0 -> VPAW.
  - Else counter == TIMEOUT -> REC. If the cycle is not posted, IOBERR=1 (held until ASInactive). A posted write that times out is dropped silently.
- VPAW:
  - Wait until ECnt == EDIV-1, i.e. the last cycle of E high, then -> LATCH.
  - If VPAW is entered while E is already high, it still waits for that period's ECnt == EDIV-1 (no re-sync to the next period).
- LATCH:
  - IOLatch=1 for exactly this cycle; IOASOut is still 1.
  - For a non-posted cycle, IORDY rises on exit.
  - Next state REC.
- REC:
  - IOASOut=0 for RECOV cycles, then -> IDLE.
  - Captures are blocked until back in IDLE.
  - A Req pending during REC is taken on the first IDLE cycle.
- IORDY/IOBERR clear: both clear on the edge after ASInactive=1, with priority over any set in the same cycle.
- FSB abort: if ASInactive rises while the bridge is in ACT/VPAW for a non-posted cycle, the I/O cycle still runs to REC; its IORDY is suppressed.
- Counter widths:
  - Timeout counter is ceil(log2(TIMEOUT+1)) bits, reset on ACT entry.
  - ECnt is ceil(log2(EDIV)) bits.
- Invariant: IOASOut is never 1 in IDLE or REC.

Test Plan:
- Reset: assert RES mid-ACT -> next edge IOASOut=0, IORDY=0, IOE=0, state IDLE; after release, IOE first rises when ECnt=6 (EDIV=10, EHIGH=4).
- DTACK read:
  - Stimulus: IOCS=1, nWE=1, ASActive at cycle 0; IOnDTACK=0 at cycle 3.
  - Response: IOASOut=1 cycles 1-4, IOLatch=1 cycle 4, IORDY=1 from cycle 5 until the edge after ASInactive.
  - Then IOASOut=0 for 2 cycles.
- VPA read: IACS=1, IOnVPA=0 in ACT with ECnt=2 -> IOLatch exactly when ECnt=9, IORDY next cycle; IOE high throughout ECnt 6-9.
- Posted write:
  - Stimulus: IOCS=1, nWE=0.
  - Response: IORDY=1 one cycle after capture; I/O cycle completes independently.
  - Second IOCS request during REC is captured on the first IDLE cycle.
- Timeout: no DTACK/VPA on a read -> IOBERR=1 after 64 cycles in ACT, IOLatch never pulses; a posted write with no DTACK -> no IOBERR.
- Simultaneous: IOnDTACK=0 and IOnVPA=0 in the same cycle -> DTACK path taken (IOLatch next cycle, no E-sync wait).
